if_stage_fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage ARM pipeline. Directly upstream of decode and of the hazard detection unit, and consumes that unit's stall output as `freeze`. Holds the PC and issues requests to instruction memory over a req/ready handshake. Absorbs stalls with a one-entry hold buffer and flushes on taken branches, including branches that arrive while a memory request is outstanding.

---
 rtl/if_stage_fetch_unit.sv | 127 ++++++++++++
 tb/tb_if_stage_fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage with IF/ID register, one-entry stall buffer and
// branch redirect that also covers a branch arriving while a fetch is in flight.
module if_stage_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [INST_WIDTH-1:0] if_id_inst,
  output logic                  if_id_valid,
  output logic                  fetch_stall
);

  // state | meaning
  // FETCH | request outstanding at pc
  // HOLD  | fetched word parked in hold buffer while decode is frozen
  // DRAIN | branch seen mid-request; finish old request, then jump to pending
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, pending, pending_nxt, hold_pc, hold_pc_nxt;
  logic [INST_WIDTH-1:0] hold_inst, hold_inst_nxt;
  logic [ADDR_WIDTH-1:0] if_id_pc_nxt;
  logic [INST_WIDTH-1:0] if_id_inst_nxt;
  logic                  if_id_valid_nxt;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign pc_inc      = pc + ADDR_WIDTH'(4);
  assign imem_addr   = pc;
  // Gated by reset so no request is visible while the block is held in reset.
  assign imem_req    = rst && (state != HOLD);
  assign fetch_stall = imem_req & ~imem_ready;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pending_nxt     = pending;
    hold_pc_nxt     = hold_pc;
    hold_inst_nxt   = hold_inst;
    if_id_pc_nxt    = if_id_pc;
    if_id_inst_nxt  = if_id_inst;
    if_id_valid_nxt = if_id_valid;
    unique case (state)
      FETCH: begin
        if (branch_taken) begin
          if_id_valid_nxt = 1'b0;
          if_id_inst_nxt  = '0;
          if (imem_ready) begin
            pc_nxt = branch_addr;
          end else begin
            pending_nxt = branch_addr;
            state_nxt   = DRAIN;
          end
        end else if (imem_ready) begin
          if (freeze) begin
            hold_pc_nxt   = pc_inc;
            hold_inst_nxt = imem_rdata;
            state_nxt     = HOLD;
          end else begin
            if_id_pc_nxt    = pc_inc;
            if_id_inst_nxt  = imem_rdata;
            if_id_valid_nxt = 1'b1;
            pc_nxt          = pc_inc;
          end
        end else if (!freeze) begin
          if_id_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_nxt          = branch_addr;
          if_id_valid_nxt = 1'b0;
          if_id_inst_nxt  = '0;
          state_nxt       = FETCH;
        end else if (!freeze) begin
          if_id_pc_nxt    = hold_pc;
          if_id_inst_nxt  = hold_inst;
          if_id_valid_nxt = 1'b1;
          pc_nxt          = pc_inc;
          state_nxt       = FETCH;
        end
      end
      DRAIN: begin
        if_id_valid_nxt = 1'b0;
        if_id_inst_nxt  = '0;
        if (branch_taken) pending_nxt = branch_addr;
        if (imem_ready) begin
          pc_nxt    = branch_taken ? branch_addr : pending;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pending     <= '0;
      hold_pc     <= '0;
      hold_inst   <= '0;
      if_id_pc    <= '0;
      if_id_inst  <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pending     <= pending_nxt;
      hold_pc     <= hold_pc_nxt;
      hold_inst   <= hold_inst_nxt;
      if_id_pc    <= if_id_pc_nxt;
      if_id_inst  <= if_id_inst_nxt;
      if_id_valid <= if_id_valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed bench for if_stage_fetch_unit; memory returns its own address as data.
module tb_if_stage_fetch_unit;
  logic        clk = 1'b0, rst = 1'b0, freeze = 1'b0, branch_taken = 1'b0, imem_ready = 1'b1;
  logic [31:0] branch_addr = '0, imem_addr, imem_rdata, if_id_pc, if_id_inst;
  logic        imem_req, if_id_valid, fetch_stall;
  int n_cmp = 0, n_err = 0;

  if_stage_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .fetch_stall(fetch_stall)
  );

  assign imem_rdata = imem_addr;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1; branch_addr = '0;
    step();
    rst = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; step();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== 65'd0) begin n_err++; $display("FAIL rst_ifid got %h/%h/%b exp 0", if_id_pc, if_id_inst, if_id_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    rst = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rel_req got %b exp 1", imem_req); end
  endtask

  task automatic test_zero_wait_and_waits();
    do_reset();
    step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h4, 32'h0, 1'b1}) begin n_err++; $display("FAIL zw1 got %h/%h/%b exp 4/0/1", if_id_pc, if_id_inst, if_id_valid); end
    step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h8, 32'h4, 1'b1}) begin n_err++; $display("FAIL zw2 got %h/%h/%b exp 8/4/1", if_id_pc, if_id_inst, if_id_valid); end
    n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL zw_addr got %h exp 8", imem_addr); end
    imem_ready = 1'b0; #1;
    n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL ws_stall got %b exp 1", fetch_stall); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if ({imem_addr, imem_req, fetch_stall, if_id_valid} !== {32'h8, 3'b110}) begin n_err++; $display("FAIL ws_bubble%0d got %h/%b/%b/%b exp 8/1/1/0", i, imem_addr, imem_req, fetch_stall, if_id_valid); end
    end
    imem_ready = 1'b1; step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'hc, 32'h8, 1'b1}) begin n_err++; $display("FAIL ws_done got %h/%h/%b exp c/8/1", if_id_pc, if_id_inst, if_id_valid); end
    n_cmp++; if (imem_addr !== 32'hc) begin n_err++; $display("FAIL ws_addr got %h exp c", imem_addr); end
  endtask

  task automatic test_freeze();
    do_reset();
    step();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h4, 32'h0, 1'b1}) begin n_err++; $display("FAIL frz_hold%0d got %h/%h/%b exp 4/0/1", i, if_id_pc, if_id_inst, if_id_valid); end
      n_cmp++; if ({imem_req, imem_addr} !== {1'b0, 32'h4}) begin n_err++; $display("FAIL frz_req%0d got %b/%h exp 0/4", i, imem_req, imem_addr); end
    end
    freeze = 1'b0; step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h8, 32'h4, 1'b1}) begin n_err++; $display("FAIL frz_rel got %h/%h/%b exp 8/4/1", if_id_pc, if_id_inst, if_id_valid); end
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL frz_resume got %b/%h exp 1/8", imem_req, imem_addr); end
    step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'hc, 32'h8, 1'b1}) begin n_err++; $display("FAIL frz_next got %h/%h/%b exp c/8/1", if_id_pc, if_id_inst, if_id_valid); end
  endtask

  task automatic test_branch_freeze();
    do_reset();
    step();
    freeze = 1'b1; step();
    branch_taken = 1'b1; branch_addr = 32'h100; step();
    n_cmp++; if ({if_id_inst, if_id_valid} !== 33'd0) begin n_err++; $display("FAIL bh_flush got %h/%b exp 0/0", if_id_inst, if_id_valid); end
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL bh_addr got %b/%h exp 1/100", imem_req, imem_addr); end
    branch_taken = 1'b0; freeze = 1'b0; step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h104, 32'h100, 1'b1}) begin n_err++; $display("FAIL bh_next got %h/%h/%b exp 104/100/1", if_id_pc, if_id_inst, if_id_valid); end
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h40; step();
    n_cmp++; if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h40, 1'b0}) begin n_err++; $display("FAIL bf_fetch got %b/%h/%b exp 1/40/0", imem_req, imem_addr, if_id_valid); end
    branch_taken = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    branch_taken = 1'b1; branch_addr = 32'hffff_fffc; step();
    branch_taken = 1'b0; step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h0, 32'hffff_fffc, 1'b1}) begin n_err++; $display("FAIL wrap got %h/%h/%b exp 0/fffffffc/1", if_id_pc, if_id_inst, if_id_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_branch_during_wait();
    do_reset();
    branch_taken = 1'b1; branch_addr = 32'h20; step();
    branch_taken = 1'b0; imem_ready = 1'b0; step();
    branch_taken = 1'b1; branch_addr = 32'h200; step();
    n_cmp++; if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h20, 1'b0}) begin n_err++; $display("FAIL bw_drain1 got %b/%h/%b exp 1/20/0", imem_req, imem_addr, if_id_valid); end
    branch_addr = 32'h300; freeze = 1'b1; step();
    n_cmp++; if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h20, 1'b0}) begin n_err++; $display("FAIL bw_drain2 got %b/%h/%b exp 1/20/0", imem_req, imem_addr, if_id_valid); end
    branch_taken = 1'b0; imem_ready = 1'b1; step();
    n_cmp++; if ({imem_addr, if_id_valid, if_id_inst} !== {32'h300, 1'b0, 32'h0}) begin n_err++; $display("FAIL bw_redirect got %h/%b/%h exp 300/0/0", imem_addr, if_id_valid, if_id_inst); end
    freeze = 1'b0; step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h304, 32'h300, 1'b1}) begin n_err++; $display("FAIL bw_next got %h/%h/%b exp 304/300/1", if_id_pc, if_id_inst, if_id_valid); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h80; step();
    branch_taken = 1'b0;
    #2 rst = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmw_req got %b exp 0", imem_req); end
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid, imem_addr} !== 97'd0) begin n_err++; $display("FAIL rmw_ifid got %h/%h/%b/%h exp 0", if_id_pc, if_id_inst, if_id_valid, imem_addr); end
    step();
    rst = 1'b1; imem_ready = 1'b1; #1;
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL rmw_rel got %b/%h exp 1/0", imem_req, imem_addr); end
    step();
    n_cmp++; if ({if_id_pc, if_id_inst, if_id_valid} !== {32'h4, 32'h0, 1'b1}) begin n_err++; $display("FAIL rmw_fetch got %h/%h/%b exp 4/0/1", if_id_pc, if_id_inst, if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_and_waits();
    test_freeze();
    test_branch_freeze();
    test_wrap();
    test_branch_during_wait();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
